// File: rtl/c_fetch_buffer.sv
// rtl/c_fetch_buffer.sv - halfword-granular instruction prefetch buffer
//
// Fetches aligned words from the I-cache, keeps them as halfwords in a small
// circular queue and presents the head as a 32-bit window for the
// compressed-extension stage, so word-straddling 32-bit instructions need no
// refetch.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   flush_i, flush_pc_i redirect and its halfword-aligned target
//   ic_req_o, ic_addr_o fetch request and its word address
//   ic_gnt_i            I-cache accepts the request
//   ic_rsp_valid_i/data response word (little-endian halfwords)
//   out_valid_o/ready_i instruction handshake towards the decoder
//   out_instr_o         {next halfword, head halfword}
//   out_pc_o            PC of the head halfword
//   out_is_comp_o       head halfword is a compressed instruction
module c_fetch_buffer #(
   parameter int unsigned DEPTH_HW = 8,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   output logic        ic_req_o,
   output logic [31:0] ic_addr_o,
   input  logic        ic_gnt_i,
   input  logic        ic_rsp_valid_i,
   input  logic [31:0] ic_rsp_data_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_instr_o,
   output logic [31:0] out_pc_o,
   output logic        out_is_comp_o
);

   localparam int unsigned PW = $clog2(DEPTH_HW);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH_HW);

   logic [15:0]   mem [DEPTH_HW];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [31:0]   fetch_pc;
   logic [31:0]   out_pc;
   logic          drop_low;
   logic          outstanding;
   logic          kill;

   logic [15:0]   head_hw;
   logic [15:0]   next_hw;
   logic          has_one;
   logic          has_two;
   logic          head_comp;
   logic          pop;
   logic [CW-1:0] pop_n;
   logic [CW-1:0] push_n;
   logic [CW-1:0] count_after_pop;
   logic          rsp_take;
   logic          rsp_write;
   logic [15:0]   wr_hw0;
   logic [15:0]   wr_hw1;

   always_comb begin
      has_one   = (count != '0);
      has_two   = (count >= CW'(2));
      head_hw   = has_one ? mem[rd_ptr] : 16'h0;
      next_hw   = has_two ? mem[rd_ptr + PW'(1)] : 16'h0;
      head_comp = has_one && (head_hw[1:0] != 2'b11);

      out_valid_o   = !flush_i && (head_comp || has_two);
      out_instr_o   = {next_hw, head_hw};
      out_pc_o      = out_pc;
      out_is_comp_o = head_comp;

      pop   = out_valid_o && out_ready_i;
      pop_n = '0;
      if (pop) begin
         pop_n = head_comp ? CW'(1) : CW'(2);
      end
      count_after_pop = count - pop_n;

      // Space is judged after this cycle's pop; with a single outstanding
      // request, two free slots here can never be consumed before the
      // response lands. Reset gating keeps the request low while held.
      ic_req_o  = reset && !outstanding && !kill && !flush_i &&
                  ((DEPTH_C - count_after_pop) >= CW'(2));
      ic_addr_o = {fetch_pc[31:2], 2'b00};

      // Responses are only meaningful while a request is in flight, so a
      // late response after reset is ignored.
      rsp_take  = ic_rsp_valid_i && outstanding;
      rsp_write = rsp_take && !kill && !flush_i;
      push_n    = '0;
      if (rsp_write) begin
         push_n = drop_low ? CW'(1) : CW'(2);
      end
      wr_hw0 = drop_low ? ic_rsp_data_i[31:16] : ic_rsp_data_i[15:0];
      wr_hw1 = ic_rsp_data_i[31:16];
   end

   // Halfword storage; contents are only observed when count says so.
   always_ff @(posedge clk) begin
      if (rsp_write) begin
         mem[wr_ptr] <= wr_hw0;
         if (!drop_low) begin
            mem[wr_ptr + PW'(1)] <= wr_hw1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         fetch_pc    <= RESET_PC;
         out_pc      <= RESET_PC;
         drop_low    <= RESET_PC[1];
         outstanding <= 1'b0;
         kill        <= 1'b0;
      end else if (flush_i) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         out_pc      <= {flush_pc_i[31:1], 1'b0};
         fetch_pc    <= {flush_pc_i[31:2], 2'b00};
         drop_low    <= flush_pc_i[1];
         // A response arriving with the flush is simply dropped; otherwise
         // the in-flight one must be swallowed when it shows up.
         outstanding <= outstanding && !ic_rsp_valid_i;
         kill        <= outstanding && !ic_rsp_valid_i;
      end else begin
         if (ic_req_o && ic_gnt_i) begin
            outstanding <= 1'b1;
            fetch_pc    <= fetch_pc + 32'd4;
         end else if (rsp_take) begin
            outstanding <= 1'b0;
            kill        <= 1'b0;
         end
         if (rsp_write) begin
            drop_low <= 1'b0;
         end
         rd_ptr <= rd_ptr + pop_n[PW-1:0];
         wr_ptr <= wr_ptr + push_n[PW-1:0];
         count  <= count_after_pop + push_n;
         out_pc <= out_pc + 32'({pop_n, 1'b0});
      end
   end

endmodule

// File: tb/tb_c_fetch_buffer.sv
// tb/tb_c_fetch_buffer.sv - scoreboard bench for c_fetch_buffer
module tb_c_fetch_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush_i;
   logic [31:0] flush_pc_i;
   logic        ic_req_o;
   logic [31:0] ic_addr_o;
   logic        ic_gnt_i;
   logic        ic_rsp_valid_i;
   logic [31:0] ic_rsp_data_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_instr_o;
   logic [31:0] out_pc_o;
   logic        out_is_comp_o;

   logic        auto_mode;
   logic        a_valid;
   logic [31:0] a_data;
   logic        m_valid;
   logic [31:0] m_data;
   int          lat;

   assign ic_rsp_valid_i = auto_mode ? a_valid : m_valid;
   assign ic_rsp_data_i  = auto_mode ? a_data  : m_data;

   always #5 clk = ~clk;

   c_fetch_buffer #(.DEPTH_HW(8), .RESET_PC(32'h0000_0100)) dut (
      .clk(clk), .reset(reset), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
      .ic_req_o(ic_req_o), .ic_addr_o(ic_addr_o), .ic_gnt_i(ic_gnt_i),
      .ic_rsp_valid_i(ic_rsp_valid_i), .ic_rsp_data_i(ic_rsp_data_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_instr_o(out_instr_o), .out_pc_o(out_pc_o), .out_is_comp_o(out_is_comp_o)
   );

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        comp;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] exp_addr[$];
   int          checks = 0;
   int          errors = 0;
   int          gnt_cnt = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h100: return 32'h0001_0093;
         32'h104: return 32'h4501_4505;
         32'h300: return 32'h0093_4505;
         32'h304: return 32'hABCD_0001;
         32'h400: return 32'hDEAD_BEEF;
         32'h204: return 32'h4505_1111;
         32'h208: return 32'h0001_0093;
         32'h500: return 32'h0001_0093;
         32'h504: return 32'h4509_4511;
         32'h508: return 32'h0113_4515;
         32'h50C: return 32'h4519_0002;
         default: return 32'h0001_0001;
      endcase
   endfunction

   function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc, input logic comp);
      exp_t e;
      e.instr = instr;
      e.pc    = pc;
      e.comp  = comp;
      return e;
   endfunction

   // I-cache model: one request at a time, fixed latency in cycles.
   initial begin : icache
      logic        pend;
      logic [31:0] paddr;
      int          cnt;
      pend = 1'b0; paddr = '0; cnt = 0;
      a_valid = 1'b0; a_data = '0;
      forever begin
         @(negedge clk);
         if (!reset) pend = 1'b0;
         if (reset && ic_req_o && ic_gnt_i) begin
            pend = 1'b1; paddr = ic_addr_o; cnt = lat;
         end
         @(posedge clk); #1;
         a_valid = 1'b0;
         if (pend) begin
            cnt--;
            if (cnt <= 0) begin
               a_valid = 1'b1; a_data = mem_word(paddr); pend = 1'b0;
            end
         end
      end
   end

   // Monitor: pops and compares whenever the DUT hands something over.
   initial begin : monitor
      exp_t        e;
      logic [31:0] a;
      logic        ok;
      forever begin
         @(negedge clk);
         if (reset && out_valid_o && out_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: pc=%h instr=%h, required no output", out_pc_o, out_instr_o);
            end else begin
               e = exp_q.pop_front();
               if (e.comp)
                  ok = (out_instr_o[15:0] == e.instr[15:0]) &&
                       (out_instr_o[31:16] == 16'h0 || out_instr_o[31:16] == e.instr[31:16]) &&
                       (out_pc_o == e.pc) && out_is_comp_o;
               else
                  ok = (out_instr_o == e.instr) && (out_pc_o == e.pc) && !out_is_comp_o;
               if (!ok) begin
                  errors++;
                  $display("FAIL sb_out: pc=%h instr=%h comp=%b, required pc=%h instr=%h comp=%b",
                           out_pc_o, out_instr_o, out_is_comp_o, e.pc, e.instr, e.comp);
               end
            end
         end
         if (reset && ic_req_o && ic_gnt_i) begin
            gnt_cnt++;
            if (exp_addr.size() != 0) begin
               a = exp_addr.pop_front();
               checks++;
               if (ic_addr_o !== a) begin
                  errors++;
                  $display("FAIL sb_addr: ic_addr=%h, required %h", ic_addr_o, a);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d outputs pending after %0d cycles, required 0", name, exp_q.size(), n);
         exp_q.delete();
      end
      out_ready_i = 1'b0;
   endtask

   task automatic wait_grant(input logic [31:0] addr, input string name);
      int n = 0;
      bit seen = 0;
      while (!seen && n < 50) begin
         @(negedge clk);
         n++;
         if (ic_req_o && ic_gnt_i && ic_addr_o == addr) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s: no grant of %h within %0d cycles, required one", name, addr, n);
      end
   endtask

   task automatic do_flush(input logic [31:0] pc, input bit push);
      @(posedge clk); #1;
      flush_i = 1'b1;
      flush_pc_i = pc;
      if (push) exp_addr.push_back({pc[31:2], 2'b00});
      @(posedge clk); #1;
      flush_i = 1'b0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: time limit reached, required self-termination");
      $fatal(1);
   end

   initial begin : stim
      int n;
      int g0;
      reset = 1'b0; flush_i = 1'b0; flush_pc_i = '0; ic_gnt_i = 1'b1;
      out_ready_i = 1'b0; auto_mode = 1'b1; m_valid = 1'b0; m_data = '0; lat = 1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req", 32'(ic_req_o), 32'h0);
      chk("rst_valid", 32'(out_valid_o), 32'h0);
      chk("rst_instr", out_instr_o, 32'h0);
      chk("rst_comp", 32'(out_is_comp_o), 32'h0);
      chk("rst_pc", out_pc_o, 32'h100);
      chk("rst_addr", ic_addr_o, 32'h100);

      // Sequential fetch from RESET_PC
      exp_addr.push_back(32'h100); exp_addr.push_back(32'h104); exp_addr.push_back(32'h108);
      exp_q.push_back(mk(32'h0001_0093, 32'h100, 1'b0));
      exp_q.push_back(mk(32'h4501_4505, 32'h104, 1'b1));
      exp_q.push_back(mk(32'h0001_4501, 32'h106, 1'b1));
      @(posedge clk); #1;
      reset = 1'b1; out_ready_i = 1'b1;
      wait_drain("seq_drain");

      // Straddling 32-bit instruction
      lat = 4;
      exp_q.push_back(mk(32'h0093_4505, 32'h300, 1'b1));
      exp_q.push_back(mk(32'h0001_0093, 32'h302, 1'b0));
      do_flush(32'h300, 1'b0);
      out_ready_i = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (out_pc_o != 32'h302 && n < 50);
      chk("straddle_pc", out_pc_o, 32'h302);
      chk("straddle_hold", 32'(out_valid_o), 32'h0);
      wait_drain("straddle_drain");

      // Flush to 0x206 while a request is outstanding
      lat = 5;
      do_flush(32'h400, 1'b1);
      wait_grant(32'h400, "kill_grant");
      do_flush(32'h206, 1'b1);
      exp_addr.push_back(32'h208);
      lat = 1;
      exp_q.push_back(mk(32'h0093_4505, 32'h206, 1'b1));
      exp_q.push_back(mk(32'h0001_0093, 32'h208, 1'b0));
      out_ready_i = 1'b1;
      wait_drain("kill_drain");

      // Backpressure: buffer fills to DEPTH_HW and fetching stops
      do_flush(32'h500, 1'b1);
      exp_addr.push_back(32'h504); exp_addr.push_back(32'h508); exp_addr.push_back(32'h50C);
      g0 = gnt_cnt;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("bp_req_off", 32'(ic_req_o), 32'h0);
      chk("bp_grants", 32'(gnt_cnt - g0), 32'd4);
      exp_q.push_back(mk(32'h0001_0093, 32'h500, 1'b0));
      exp_q.push_back(mk(32'h4509_4511, 32'h504, 1'b1));
      exp_q.push_back(mk(32'h4515_4509, 32'h506, 1'b1));
      exp_q.push_back(mk(32'h0113_4515, 32'h508, 1'b1));
      exp_q.push_back(mk(32'h0002_0113, 32'h50A, 1'b0));
      exp_q.push_back(mk(32'h0001_4519, 32'h50E, 1'b1));
      @(posedge clk); #1;
      out_ready_i = 1'b1;
      wait_drain("bp_drain");

      // Flush coincident with a response and out_ready_i
      ic_gnt_i = 1'b0;
      repeat (6) @(posedge clk);
      #1 auto_mode = 1'b0;
      do_flush(32'h600, 1'b1);
      ic_gnt_i = 1'b1;
      wait_grant(32'h600, "coinc_grant");
      @(posedge clk); #1;
      flush_i = 1'b1; flush_pc_i = 32'h701;
      m_valid = 1'b1; m_data = 32'h1234_5678; out_ready_i = 1'b1;
      exp_addr.push_back(32'h700);
      @(posedge clk); #1;
      flush_i = 1'b0; m_valid = 1'b0; out_ready_i = 1'b0;
      @(negedge clk);
      chk("coinc_req", 32'(ic_req_o), 32'h1);
      chk("coinc_addr", ic_addr_o, 32'h700);
      chk("coinc_empty", 32'(out_valid_o), 32'h0);
      @(posedge clk); #1;
      m_valid = 1'b1; m_data = 32'h4505_4509;
      @(posedge clk); #1;
      m_valid = 1'b0;
      @(negedge clk);
      chk("coinc_out_valid", 32'(out_valid_o), 32'h1);
      chk("coinc_out_pc", out_pc_o, 32'h700);
      chk("coinc_out_instr", out_instr_o, 32'h4505_4509);
      chk("coinc_out_comp", 32'(out_is_comp_o), 32'h1);

      // Async reset with a request in flight
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      chk("arst_req", 32'(ic_req_o), 32'h0);
      chk("arst_valid", 32'(out_valid_o), 32'h0);
      chk("arst_instr", out_instr_o, 32'h0);
      chk("arst_comp", 32'(out_is_comp_o), 32'h0);
      chk("arst_pc", out_pc_o, 32'h100);
      ic_gnt_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1; m_valid = 1'b1; m_data = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("arst_req_after", 32'(ic_req_o), 32'h1);
      chk("arst_addr_after", ic_addr_o, 32'h100);
      @(posedge clk); #1;
      m_valid = 1'b0;
      @(negedge clk);
      chk("arst_late_ignored", 32'(out_valid_o), 32'h0);
      chk("arst_still_req", 32'(ic_req_o), 32'h1);

      chk("sb_left", 32'(exp_q.size()), 32'h0);
      chk("addr_left", 32'(exp_addr.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
